jrc_seq_ctrl: RTL and testbench

Sequencing controller for the 4-bit Johnson (twisted-ring) pattern generator. It owns the 3-bit phase register and steps it forward or backward at a programmable rate. Three run modes: continuous, counted N-step, and single-step. A start/stop/busy/done handshake lets a host FSM or pushbutton logic drive it without knowing the pattern.

---
 rtl/jrc_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_jrc_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jrc_seq_ctrl.sv
// jrc_seq_ctrl: sequencing controller for a 4-bit Johnson pattern generator.
// Steps a 3-bit phase register forward/backward at a programmable rate in
// continuous, counted or single-step mode, with a start/stop/busy/done handshake.
// Ports:
//   iClk, iRst_n         clock (rising edge), async active-low reset
//   iStart, iStop        run request (IDLE only) / abort request (RUN only)
//   iDir                 0 forward, 1 reverse
//   iMode                0 continuous, 1 counted, 2/3 single
//   iSteps, iDiv         step count (counted mode), step every iDiv+1 clocks
//   oQ, oPhase           Johnson pattern and raw phase
//   oBusy, oStep, oDone  running, phase-change pulse, completion pulse
module jrc_seq_ctrl #(
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic               iStop,
  input  logic               iDir,
  input  logic [1:0]         iMode,
  input  logic [CNT_W-1:0]   iSteps,
  input  logic [PRESC_W-1:0] iDiv,
  output logic [3:0]         oQ,
  output logic [2:0]         oPhase,
  output logic               oBusy,
  output logic               oStep,
  output logic               oDone
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] MODE_CONT = 2'd0;
  localparam logic [1:0] MODE_CNT  = 2'd1;

  state_t             state, stateNext;
  logic [2:0]         phase, phaseNext;
  logic [PRESC_W-1:0] presc, prescNext;
  logic [CNT_W-1:0]   remaining, remainingNext;
  logic               cfgDir, cfgDirNext;
  logic [1:0]         cfgMode, cfgModeNext;
  logic [PRESC_W-1:0] cfgDiv, cfgDivNext;
  logic               stepNext;
  logic               tick;

  logic [3:0]         qReg;
  logic               busyReg, stepReg, doneReg;

  // Johnson decode of the phase
  function automatic logic [3:0] johnson(input logic [2:0] ph);
    logic [3:0] q;
    case (ph)
      3'd0:    q = 4'b0000;
      3'd1:    q = 4'b1000;
      3'd2:    q = 4'b1100;
      3'd3:    q = 4'b1110;
      3'd4:    q = 4'b1111;
      3'd5:    q = 4'b0111;
      3'd6:    q = 4'b0011;
      default: q = 4'b0001;
    endcase
    return q;
  endfunction

  assign tick = (presc == cfgDiv);

  // Next-state and datapath update
  always_comb begin
    stateNext     = state;
    phaseNext     = phase;
    prescNext     = presc;
    remainingNext = remaining;
    cfgDirNext    = cfgDir;
    cfgModeNext   = cfgMode;
    cfgDivNext    = cfgDiv;
    stepNext      = 1'b0;

    case (state)
      IDLE: begin
        if (iStart && !iStop) begin
          cfgDirNext  = iDir;
          cfgModeNext = iMode;
          cfgDivNext  = iDiv;
          prescNext   = '0;
          if (iMode == MODE_CNT) begin
            remainingNext = iSteps;
            // A zero-length counted run completes without ever stepping
            stateNext     = (iSteps == '0) ? DONE : RUN;
          end else begin
            remainingNext = (iMode == MODE_CONT) ? '0 : CNT_W'(1);
            stateNext     = RUN;
          end
        end
      end

      RUN: begin
        // Stop wins over a coincident tick: phase holds, no step
        if (iStop) begin
          stateNext = IDLE;
        end else if (tick) begin
          phaseNext = cfgDir ? (phase - 3'd1) : (phase + 3'd1);
          stepNext  = 1'b1;
          prescNext = '0;
          if (cfgMode != MODE_CONT) begin
            remainingNext = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) stateNext = DONE;
          end
        end else begin
          prescNext = presc + PRESC_W'(1);
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      phase     <= '0;
      presc     <= '0;
      remaining <= '0;
      cfgDir    <= 1'b0;
      cfgMode   <= '0;
      cfgDiv    <= '0;
      qReg      <= '0;
      busyReg   <= 1'b0;
      stepReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      phase     <= phaseNext;
      presc     <= prescNext;
      remaining <= remainingNext;
      cfgDir    <= cfgDirNext;
      cfgMode   <= cfgModeNext;
      cfgDiv    <= cfgDivNext;
      qReg      <= johnson(phaseNext);
      busyReg   <= (stateNext == RUN);
      stepReg   <= stepNext;
      doneReg   <= (stateNext == DONE);
    end
  end

  assign oQ     = qReg;
  assign oPhase = phase;
  assign oBusy  = busyReg;
  assign oStep  = stepReg;
  assign oDone  = doneReg;

endmodule

// File: tb/tb_jrc_seq_ctrl.sv
// Directed testbench for jrc_seq_ctrl.
module tb_jrc_seq_ctrl;
  localparam int unsigned PRESC_W = 16;
  localparam int unsigned CNT_W   = 8;

  logic               iClk   = 1'b0;
  logic               iRst_n = 1'b0;
  logic               iStart = 1'b0;
  logic               iStop  = 1'b0;
  logic               iDir   = 1'b0;
  logic [1:0]         iMode  = 2'd0;
  logic [CNT_W-1:0]   iSteps = '0;
  logic [PRESC_W-1:0] iDiv   = '0;
  logic [3:0]         oQ;
  logic [2:0]         oPhase;
  logic               oBusy, oStep, oDone;

  int nChecks = 0;
  int nPass   = 0;

  jrc_seq_ctrl #(.PRESC_W(PRESC_W), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStop(iStop),
    .iDir(iDir), .iMode(iMode), .iSteps(iSteps), .iDiv(iDiv),
    .oQ(oQ), .oPhase(oPhase), .oBusy(oBusy), .oStep(oStep), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  // Advance into the next cycle; outputs are sampled 1 time unit after the edge
  task automatic stepClk;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    nChecks++;
    if ({oQ, oPhase, oBusy, oStep, oDone} !== 12'h000)
      $display("FAIL reset_assert: got %h want 000", {oQ, oPhase, oBusy, oStep, oDone});
    else nPass++;
    stepClk();
    iRst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stepClk();
      nChecks++;
      if ({oQ, oPhase, oBusy, oStep, oDone} !== 12'h000)
        $display("FAIL reset_idle[%0d]: got %h want 000", k, {oQ, oPhase, oBusy, oStep, oDone});
      else nPass++;
    end
  endtask

  task automatic test_continuous;
    logic [3:0] expQ [9];
    expQ = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
             4'b0011, 4'b0001, 4'b0000, 4'b1000};
    iMode = 2'd0; iDir = 1'b0; iDiv = '0; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    nChecks++;
    if ({oBusy, oStep, oPhase, oQ} !== {1'b1, 1'b0, 3'd0, 4'b0000})
      $display("FAIL cont_first: got %b want 1000000000", {oBusy, oStep, oPhase, oQ});
    else nPass++;
    for (int i = 0; i < 9; i++) begin
      stepClk();
      nChecks++;
      if ({oBusy, oStep, oPhase, oQ} !== {1'b1, 1'b1, 3'((i + 1) % 8), expQ[i]})
        $display("FAIL cont_step[%0d]: got %b want %b", i, {oBusy, oStep, oPhase, oQ},
                 {1'b1, 1'b1, 3'((i + 1) % 8), expQ[i]});
      else nPass++;
    end
    // Stop lands on a cycle that would otherwise tick (div=0)
    iStop = 1'b1;
    stepClk();
    iStop = 1'b0;
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b000, 3'd1})
      $display("FAIL cont_stop: got %b want 000001", {oBusy, oStep, oDone, oPhase});
    else nPass++;
    stepClk();
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b000, 3'd1})
      $display("FAIL cont_stop_idle: got %b want 000001", {oBusy, oStep, oDone, oPhase});
    else nPass++;
  endtask

  task automatic test_counted_reverse;
    logic [2:0] expPhase;
    logic       expStep, expDone, expBusy;
    iRst_n = 1'b0;
    #2;
    iRst_n = 1'b1;
    stepClk();
    iMode = 2'd1; iDir = 1'b1; iSteps = 8'd3; iDiv = 16'd2; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      expPhase = (k < 4) ? 3'd0 : (k < 7) ? 3'd7 : (k < 10) ? 3'd6 : 3'd5;
      expStep  = (k == 4) || (k == 7) || (k == 10);
      expDone  = (k == 10);
      expBusy  = (k < 10);
      nChecks++;
      if ({oPhase, oStep, oDone, oBusy} !== {expPhase, expStep, expDone, expBusy})
        $display("FAIL cnt_rev[N+%0d]: got %b want %b", k, {oPhase, oStep, oDone, oBusy},
                 {expPhase, expStep, expDone, expBusy});
      else nPass++;
      if (k == 2)  iDiv = '0;        // live divider change must be ignored
      if (k == 5)  iStart = 1'b1;    // start during RUN ignored
      if (k == 6)  iStart = 1'b0;
      if (k == 10) iStart = 1'b1;    // start during DONE ignored
      if (k == 11) iStart = 1'b0;
      if (k < 12) stepClk();
    end
    nChecks++;
    if (oQ !== 4'b0111) $display("FAIL cnt_rev_q: got %b want 0111", oQ);
    else nPass++;
  endtask

  task automatic test_zero_and_single;
    logic [2:0] expPhase;
    logic       expStep, expDone, expBusy;
    iMode = 2'd1; iSteps = '0; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b001, 3'd5})
      $display("FAIL zero_done: got %b want 001101", {oBusy, oStep, oDone, oPhase});
    else nPass++;
    stepClk();
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b000, 3'd5})
      $display("FAIL zero_after: got %b want 000101", {oBusy, oStep, oDone, oPhase});
    else nPass++;

    iMode = 2'd3; iDiv = 16'd1; iDir = 1'b0; iSteps = 8'd7; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expPhase = (k >= 3) ? 3'd6 : 3'd5;
      expStep  = (k == 3);
      expDone  = (k == 3);
      expBusy  = (k < 3);
      nChecks++;
      if ({oPhase, oStep, oDone, oBusy} !== {expPhase, expStep, expDone, expBusy})
        $display("FAIL single[N+%0d]: got %b want %b", k, {oPhase, oStep, oDone, oBusy},
                 {expPhase, expStep, expDone, expBusy});
      else nPass++;
      if (k < 5) stepClk();
    end
    nChecks++;
    if (oQ !== 4'b0011) $display("FAIL single_q: got %b want 0011", oQ);
    else nPass++;
  endtask

  task automatic test_races;
    iMode = 2'd0; iDir = 1'b0; iStart = 1'b1; iStop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepClk();
      nChecks++;
      if ({oBusy, oDone, oPhase} !== {2'b00, 3'd6})
        $display("FAIL race_both[%0d]: got %b want 00110", k, {oBusy, oDone, oPhase});
      else nPass++;
    end
    iStart = 1'b0; iStop = 1'b0;
    iDiv = 16'd2; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    nChecks++;
    if (oBusy !== 1'b1) $display("FAIL race_run_busy: got %b want 1", oBusy);
    else nPass++;
    stepClk();
    stepClk();
    nChecks++;
    if ({oBusy, oStep, oPhase} !== {2'b10, 3'd6})
      $display("FAIL race_pretick: got %b want 10110", {oBusy, oStep, oPhase});
    else nPass++;
    // This cycle's prescaler equals div: stop must suppress the tick
    iStop = 1'b1;
    stepClk();
    iStop = 1'b0;
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b000, 3'd6})
      $display("FAIL race_stop_tick: got %b want 000110", {oBusy, oStep, oDone, oPhase});
    else nPass++;
    stepClk();
    nChecks++;
    if ({oBusy, oStep, oDone, oPhase} !== {3'b000, 3'd6})
      $display("FAIL race_stop_idle: got %b want 000110", {oBusy, oStep, oDone, oPhase});
    else nPass++;
  endtask

  task automatic test_wrap_and_reset;
    int nSteps, nDones, doneAt;
    iMode = 2'd1; iDir = 1'b0; iSteps = 8'd10; iDiv = '0; iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    nSteps = 0; nDones = 0; doneAt = -1;
    for (int k = 1; k <= 14; k++) begin
      if (oStep === 1'b1) nSteps++;
      if (oDone === 1'b1) begin
        nDones++;
        if (doneAt < 0) doneAt = k;
      end
      if (k < 14) stepClk();
    end
    nChecks++;
    if (nSteps != 10) $display("FAIL wrap_steps: got %0d want 10", nSteps);
    else nPass++;
    nChecks++;
    if (nDones != 1 || doneAt != 11)
      $display("FAIL wrap_done: got count %0d at N+%0d want 1 at N+11", nDones, doneAt);
    else nPass++;
    nChecks++;
    if ({oBusy, oPhase, oQ} !== {1'b0, 3'd0, 4'b0000})
      $display("FAIL wrap_end: got %b want 00000000", {oBusy, oPhase, oQ});
    else nPass++;

    iStart = 1'b1;
    stepClk();
    iStart = 1'b0;
    for (int k = 0; k < 4; k++) stepClk();
    nChecks++;
    if ({oBusy, oStep, oPhase} !== {2'b11, 3'd4})
      $display("FAIL rerun_4steps: got %b want 11100", {oBusy, oStep, oPhase});
    else nPass++;
    #2;
    iRst_n = 1'b0;
    #1;
    nChecks++;
    if ({oQ, oPhase, oBusy, oStep, oDone} !== 12'h000)
      $display("FAIL midrun_reset: got %h want 000", {oQ, oPhase, oBusy, oStep, oDone});
    else nPass++;
    stepClk();
    iRst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepClk();
      nChecks++;
      if ({oQ, oPhase, oBusy, oStep, oDone} !== 12'h000)
        $display("FAIL midrun_after[%0d]: got %h want 000", k, {oQ, oPhase, oBusy, oStep, oDone});
      else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_counted_reverse();
    test_zero_and_single();
    test_races();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
